// File: rtl/scalar_mult_control_if.sv
// Point-unit handshake bundle shared by the point adder and the point doubler.
// Ports (by modport):
//   master (controller side): drives start, px, py, qx, qy; receives done, x, y, inf
//   slave  (unit side)      : receives start and operands; drives done, x, y, inf
// start  - one-cycle request; operands stay stable until done
// px/py  - first operand (the only operand for the doubler)
// qx/qy  - second operand (adder only; held at zero on the doubler bundle)
// done   - one-cycle result-valid strobe
// x/y    - result coordinates
// inf    - result is the point at infinity
interface scalar_mult_control_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] px;
    logic [WIDTH-1:0] py;
    logic [WIDTH-1:0] qx;
    logic [WIDTH-1:0] qy;
    logic             done;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             inf;

    modport master (
        output start, px, py, qx, qy,
        input  done, x, y, inf
    );

    modport slave (
        input  start, px, py, qx, qy,
        output done, x, y, inf
    );
endinterface

// File: rtl/scalar_mult_control.sv
// Double-and-add controller for elliptic-curve scalar multiplication R = k*G.
// It owns the accumulator R, the doubling register Q and the scalar shift
// register K, and sequences external point-add / point-double units.
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start, abort          - begin (accepted only in IDLE) / return to IDLE
//   priv_key, gx, gy      - scalar and base point, captured on accepted start
//   busy, done            - busy outside IDLE / one-cycle result strobe
//   out_x, out_y, out_inf - result, held until the next accepted start
//   add_bus, dbl_bus      - request/response bundles to the adder and doubler
// MSB_FIRST=0 walks bits LSB first and exits as soon as no set bits remain;
// MSB_FIRST=1 walks all WIDTH bits MSB first (each bit: double phase, add phase).
module scalar_mult_control #(
    parameter int WIDTH     = 256,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     priv_key,
    input  logic [WIDTH-1:0]     gx,
    input  logic [WIDTH-1:0]     gy,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     out_x,
    output logic [WIDTH-1:0]     out_y,
    output logic                 out_inf,
    scalar_mult_control_if.master add_bus,
    scalar_mult_control_if.master dbl_bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_STEP     = 3'd2,
        ST_ADD_REQ  = 3'd3,
        ST_ADD_WAIT = 3'd4,
        ST_DBL_REQ  = 3'd5,
        ST_DBL_WAIT = 3'd6,
        ST_FINISH   = 3'd7
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] k_in_r;
    logic [WIDTH-1:0] g_x_r;
    logic [WIDTH-1:0] g_y_r;
    logic [WIDTH-1:0] r_x_r;
    logic [WIDTH-1:0] r_y_r;
    logic             r_inf_r;
    logic [WIDTH-1:0] q_x_r;
    logic [WIDTH-1:0] q_y_r;
    logic             q_inf_r;
    logic [WIDTH-1:0] k_r;
    logic [CNT_W-1:0] cnt_r;
    logic             phase_r;   // MSB_FIRST: 0 = double phase, 1 = add phase of the current bit
    logic             tgt_q_r;   // doubler result goes to Q (1) or R (0)
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] out_x_r;
    logic [WIDTH-1:0] out_y_r;
    logic             out_inf_r;
    logic             add_start_r;
    logic [WIDTH-1:0] add_px_r;
    logic [WIDTH-1:0] add_py_r;
    logic [WIDTH-1:0] add_qx_r;
    logic [WIDTH-1:0] add_qy_r;
    logic             dbl_start_r;
    logic [WIDTH-1:0] dbl_px_r;
    logic [WIDTH-1:0] dbl_py_r;
    logic             cur_bit_s;

    // Two finite points with equal coordinates must go to the doubler, not the adder.
    function automatic logic same_point(input logic [WIDTH-1:0] ax, input logic [WIDTH-1:0] ay,
                                        input logic [WIDTH-1:0] bx, input logic [WIDTH-1:0] by);
        return (ax == bx) && (ay == by);
    endfunction

    assign cur_bit_s = MSB_FIRST ? k_r[WIDTH-1] : k_r[0];

    assign busy        = busy_r;
    assign done        = done_r;
    assign out_x       = out_x_r;
    assign out_y       = out_y_r;
    assign out_inf     = out_inf_r;
    assign add_bus.start = add_start_r;
    assign add_bus.px    = add_px_r;
    assign add_bus.py    = add_py_r;
    assign add_bus.qx    = add_qx_r;
    assign add_bus.qy    = add_qy_r;
    assign dbl_bus.start = dbl_start_r;
    assign dbl_bus.px    = dbl_px_r;
    assign dbl_bus.py    = dbl_py_r;
    assign dbl_bus.qx    = '0;
    assign dbl_bus.qy    = '0;

    // Control FSM: sequences the ladder and owns every datapath and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            k_in_r      <= '0;
            g_x_r       <= '0;
            g_y_r       <= '0;
            r_x_r       <= '0;
            r_y_r       <= '0;
            r_inf_r     <= 1'b0;
            q_x_r       <= '0;
            q_y_r       <= '0;
            q_inf_r     <= 1'b0;
            k_r         <= '0;
            cnt_r       <= '0;
            phase_r     <= 1'b0;
            tgt_q_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            out_inf_r   <= 1'b0;
            add_start_r <= 1'b0;
            add_px_r    <= '0;
            add_py_r    <= '0;
            add_qx_r    <= '0;
            add_qy_r    <= '0;
            dbl_start_r <= 1'b0;
            dbl_px_r    <= '0;
            dbl_py_r    <= '0;
        end else if (abort) begin
            // Abort wins over everything, including a simultaneous start; the
            // previous result stays on out_* and any late unit response is dropped.
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            add_start_r <= 1'b0;
            dbl_start_r <= 1'b0;
        end else begin
            done_r      <= 1'b0;
            add_start_r <= 1'b0;
            dbl_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        k_in_r  <= priv_key;
                        g_x_r   <= gx;
                        g_y_r   <= gy;
                        busy_r  <= 1'b1;
                        state_r <= ST_LOAD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_x_r   <= '0;
                    r_y_r   <= '0;
                    r_inf_r <= 1'b1;
                    q_x_r   <= g_x_r;
                    q_y_r   <= g_y_r;
                    q_inf_r <= 1'b0;
                    k_r     <= k_in_r;
                    cnt_r   <= '0;
                    phase_r <= 1'b0;
                    state_r <= ST_STEP;
                end
                ST_STEP: begin
                    if (MSB_FIRST) begin
                        if ((cnt_r == CNT_W'(WIDTH)) || ((cnt_r == '0) && (k_r == '0) && !phase_r)) begin
                            // all bits consumed, or k = 0 where the answer is already infinity
                            state_r <= ST_FINISH;
                        end else if (!phase_r) begin
                            phase_r <= 1'b1;
                            if (!r_inf_r) begin
                                dbl_px_r    <= r_x_r;
                                dbl_py_r    <= r_y_r;
                                tgt_q_r     <= 1'b0;
                                dbl_start_r <= 1'b1;
                                state_r     <= ST_DBL_REQ;
                            end else begin
                                state_r <= ST_STEP;
                            end
                        end else begin
                            phase_r <= 1'b0;
                            k_r     <= k_r << 1;
                            cnt_r   <= cnt_r + CNT_W'(1);
                            if (cur_bit_s && r_inf_r) begin
                                r_x_r   <= g_x_r;
                                r_y_r   <= g_y_r;
                                r_inf_r <= 1'b0;
                                state_r <= ST_STEP;
                            end else if (cur_bit_s && same_point(r_x_r, r_y_r, g_x_r, g_y_r)) begin
                                dbl_px_r    <= r_x_r;
                                dbl_py_r    <= r_y_r;
                                tgt_q_r     <= 1'b0;
                                dbl_start_r <= 1'b1;
                                state_r     <= ST_DBL_REQ;
                            end else if (cur_bit_s) begin
                                add_px_r    <= r_x_r;
                                add_py_r    <= r_y_r;
                                add_qx_r    <= g_x_r;
                                add_qy_r    <= g_y_r;
                                add_start_r <= 1'b1;
                                state_r     <= ST_ADD_REQ;
                            end else begin
                                state_r <= ST_STEP;
                            end
                        end
                    end else begin
                        // K is shifted now; the early-exit test after an add uses the shifted K.
                        k_r   <= k_r >> 1;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cur_bit_s && !r_inf_r && !q_inf_r) begin
                            if (same_point(r_x_r, r_y_r, q_x_r, q_y_r)) begin
                                dbl_px_r    <= r_x_r;
                                dbl_py_r    <= r_y_r;
                                tgt_q_r     <= 1'b0;
                                dbl_start_r <= 1'b1;
                                state_r     <= ST_DBL_REQ;
                            end else begin
                                add_px_r    <= r_x_r;
                                add_py_r    <= r_y_r;
                                add_qx_r    <= q_x_r;
                                add_qy_r    <= q_y_r;
                                add_start_r <= 1'b1;
                                state_r     <= ST_ADD_REQ;
                            end
                        end else begin
                            // R at infinity takes a copy of Q; R + inf leaves R as is.
                            if (cur_bit_s && r_inf_r) begin
                                r_x_r   <= q_x_r;
                                r_y_r   <= q_y_r;
                                r_inf_r <= q_inf_r;
                            end else begin
                                r_inf_r <= r_inf_r;
                            end
                            if ((k_r >> 1) == '0) begin
                                state_r <= ST_FINISH;
                            end else if (q_inf_r) begin
                                state_r <= ST_STEP;
                            end else begin
                                dbl_px_r    <= q_x_r;
                                dbl_py_r    <= q_y_r;
                                tgt_q_r     <= 1'b1;
                                dbl_start_r <= 1'b1;
                                state_r     <= ST_DBL_REQ;
                            end
                        end
                    end
                end
                ST_ADD_REQ: begin
                    state_r <= ST_ADD_WAIT;
                end
                ST_ADD_WAIT: begin
                    if (add_bus.done) begin
                        r_x_r   <= add_bus.x;
                        r_y_r   <= add_bus.y;
                        r_inf_r <= add_bus.inf;
                        if (MSB_FIRST) begin
                            state_r <= ST_STEP;
                        end else if (k_r == '0) begin
                            state_r <= ST_FINISH;
                        end else if (q_inf_r) begin
                            state_r <= ST_STEP;
                        end else begin
                            dbl_px_r    <= q_x_r;
                            dbl_py_r    <= q_y_r;
                            tgt_q_r     <= 1'b1;
                            dbl_start_r <= 1'b1;
                            state_r     <= ST_DBL_REQ;
                        end
                    end else begin
                        state_r <= ST_ADD_WAIT;
                    end
                end
                ST_DBL_REQ: begin
                    state_r <= ST_DBL_WAIT;
                end
                ST_DBL_WAIT: begin
                    if (dbl_bus.done && tgt_q_r) begin
                        q_x_r   <= dbl_bus.x;
                        q_y_r   <= dbl_bus.y;
                        q_inf_r <= dbl_bus.inf;
                        state_r <= ST_STEP;
                    end else if (dbl_bus.done) begin
                        // Doubling into R: either an MSB-first double or an add routed here
                        // because R == Q; the LSB-first path then continues like after an add.
                        r_x_r   <= dbl_bus.x;
                        r_y_r   <= dbl_bus.y;
                        r_inf_r <= dbl_bus.inf;
                        if (MSB_FIRST) begin
                            state_r <= ST_STEP;
                        end else if (k_r == '0) begin
                            state_r <= ST_FINISH;
                        end else if (q_inf_r) begin
                            state_r <= ST_STEP;
                        end else begin
                            dbl_px_r    <= q_x_r;
                            dbl_py_r    <= q_y_r;
                            tgt_q_r     <= 1'b1;
                            dbl_start_r <= 1'b1;
                            state_r     <= ST_DBL_REQ;
                        end
                    end else begin
                        state_r <= ST_DBL_WAIT;
                    end
                end
                ST_FINISH: begin
                    out_x_r   <= r_x_r;
                    out_y_r   <= r_y_r;
                    out_inf_r <= r_inf_r;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_mult_control.sv
// Bench for scalar_mult_control: one instance per bit order, each attached to
// mock point units over integers mod 251 (add=(a+b)%251, dbl=2a%251, y=x),
// both answering three cycles after a request. G = (3,3), WIDTH = 8.
module tb_scalar_mult_control;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start_v [2];
    logic         abort_v [2];
    logic [W-1:0] key;
    logic [W-1:0] gx;
    logic [W-1:0] gy;
    logic         busy_v  [2];
    logic         done_v  [2];
    logic [W-1:0] ox_v    [2];
    logic [W-1:0] oy_v    [2];
    logic         oinf_v  [2];
    int           add_cnt_v  [2];
    int           dbl_cnt_v  [2];
    int           done_cnt_v [2];
    int           inf_at     [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        scalar_mult_control_if #(.WIDTH(W)) add_bus ();
        scalar_mult_control_if #(.WIDTH(W)) dbl_bus ();

        scalar_mult_control #(.WIDTH(W), .MSB_FIRST(g == 1)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start_v[g]),
            .abort    (abort_v[g]),
            .priv_key (key),
            .gx       (gx),
            .gy       (gy),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .out_x    (ox_v[g]),
            .out_y    (oy_v[g]),
            .out_inf  (oinf_v[g]),
            .add_bus  (add_bus.master),
            .dbl_bus  (dbl_bus.master)
        );

        logic [W-1:0] a_px = '0;
        logic [W-1:0] a_qx = '0;
        int           a_tmr = 0;
        int           add_cnt = 0;
        logic [W-1:0] d_px = '0;
        int           d_tmr = 0;
        int           dbl_cnt = 0;
        int           done_cnt = 0;

        assign add_cnt_v[g]  = add_cnt;
        assign dbl_cnt_v[g]  = dbl_cnt;
        assign done_cnt_v[g] = done_cnt;

        // Mock adder: a new request restarts it; answers three cycles later.
        always @(posedge clk) begin
            add_bus.done <= 1'b0;
            if (add_bus.start === 1'b1) begin
                a_px    <= add_bus.px;
                a_qx    <= add_bus.qx;
                a_tmr   <= 3;
                add_cnt <= add_cnt + 1;
            end else if (a_tmr != 0) begin
                a_tmr <= a_tmr - 1;
                if (a_tmr == 1) begin
                    add_bus.done <= 1'b1;
                    add_bus.x    <= W'((int'(a_px) + int'(a_qx)) % 251);
                    add_bus.y    <= W'((int'(a_px) + int'(a_qx)) % 251);
                    add_bus.inf  <= (add_cnt == inf_at[g]);
                end
            end
        end

        // Mock doubler: same timing as the adder.
        always @(posedge clk) begin
            dbl_bus.done <= 1'b0;
            if (dbl_bus.start === 1'b1) begin
                d_px    <= dbl_bus.px;
                d_tmr   <= 3;
                dbl_cnt <= dbl_cnt + 1;
            end else if (d_tmr != 0) begin
                d_tmr <= d_tmr - 1;
                if (d_tmr == 1) begin
                    dbl_bus.done <= 1'b1;
                    dbl_bus.x    <= W'((2 * int'(d_px)) % 251);
                    dbl_bus.y    <= W'((2 * int'(d_px)) % 251);
                    dbl_bus.inf  <= 1'b0;
                end
            end
        end

        // Count done pulses so an aborted run can be shown to produce none.
        always @(posedge clk) begin
            if (done_v[g] === 1'b1) begin
                done_cnt <= done_cnt + 1;
            end
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one multiplication on instance g and wait (bounded) for done.
    task automatic run_op(input int g, input logic [W-1:0] k, output int cyc);
        key = k;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        cyc = 0;
        while (done_v[g] !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_value("done_seen", {31'd0, done_v[g]}, 32'd1);
    endtask

    int cyc;
    int a0;
    int d0;
    int n0;

    initial begin
        reset_n    = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        abort_v[0] = 1'b0;
        abort_v[1] = 1'b0;
        inf_at[0]  = -1;
        inf_at[1]  = -1;
        key = 8'h00;
        gx  = 8'd3;
        gy  = 8'd3;
        repeat (3) @(negedge clk);

        check_value("rst_busy",   {31'd0, busy_v[0]}, 32'd0);
        check_value("rst_done",   {31'd0, done_v[0]}, 32'd0);
        check_value("rst_out_x",  {24'd0, ox_v[0]}, 32'd0);
        check_value("rst_inf",    {31'd0, oinf_v[1]}, 32'd0);
        check_value("rst_add_st", {31'd0, gen_dut[0].add_bus.start}, 32'd0);
        check_value("rst_dbl_px", {24'd0, gen_dut[1].dbl_bus.px}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // k = 0: LOAD, STEP, FINISH, infinity, no unit traffic, in both orders.
        for (int g = 0; g < 2; g++) begin
            a0 = add_cnt_v[g];
            d0 = dbl_cnt_v[g];
            run_op(g, 8'h00, cyc);
            check_value("k0_latency", cyc, 32'd3);
            check_value("k0_inf",     {31'd0, oinf_v[g]}, 32'd1);
            check_value("k0_x",       {24'd0, ox_v[g]}, 32'd0);
            check_value("k0_busy",    {31'd0, busy_v[g]}, 32'd0);
            check_value("k0_adds",    add_cnt_v[g] - a0, 32'd0);
            check_value("k0_dbls",    dbl_cnt_v[g] - d0, 32'd0);
        end

        // k = 1: G copied into R, no unit traffic, in both orders.
        for (int g = 0; g < 2; g++) begin
            a0 = add_cnt_v[g];
            d0 = dbl_cnt_v[g];
            run_op(g, 8'h01, cyc);
            check_value("k1_x",    {24'd0, ox_v[g]}, 32'd3);
            check_value("k1_y",    {24'd0, oy_v[g]}, 32'd3);
            check_value("k1_inf",  {31'd0, oinf_v[g]}, 32'd0);
            check_value("k1_adds", add_cnt_v[g] - a0, 32'd0);
            check_value("k1_dbls", dbl_cnt_v[g] - d0, 32'd0);
        end

        // k = 0x0B: 11*3 = 33 in both orders, 2 adds and 3 doubles each.
        for (int g = 0; g < 2; g++) begin
            a0 = add_cnt_v[g];
            d0 = dbl_cnt_v[g];
            run_op(g, 8'h0B, cyc);
            check_value("k0b_x",    {24'd0, ox_v[g]}, 32'd33);
            check_value("k0b_y",    {24'd0, oy_v[g]}, 32'd33);
            check_value("k0b_inf",  {31'd0, oinf_v[g]}, 32'd0);
            check_value("k0b_adds", add_cnt_v[g] - a0, 32'd2);
            check_value("k0b_dbls", dbl_cnt_v[g] - d0, 32'd3);
        end
        check_value("msb_cnt_end", {28'd0, gen_dut[1].dut.cnt_r}, 32'd8);

        // k = 0xFF on LSB-first, aborted at cycle 20: no done, result unchanged.
        key = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (18) @(negedge clk);
        check_value("ab_busy_mid", {31'd0, busy_v[0]}, 32'd1);
        n0 = done_cnt_v[0];
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        check_value("ab_idle", {31'd0, busy_v[0]}, 32'd0);
        repeat (20) @(negedge clk);
        check_value("ab_no_done", done_cnt_v[0] - n0, 32'd0);
        check_value("ab_keep_x",  {24'd0, ox_v[0]}, 32'd33);
        check_value("ab_busy",    {31'd0, busy_v[0]}, 32'd0);

        // Restart k = 0xFF with a start re-pulsed (key 0x01) while busy: 765 % 251 = 12.
        key = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        key = 8'h01;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        key = 8'hFF;
        cyc = 0;
        while (done_v[0] !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check_value("kff_done", {31'd0, done_v[0]}, 32'd1);
        check_value("kff_x",    {24'd0, ox_v[0]}, 32'd12);
        check_value("kff_inf",  {31'd0, oinf_v[0]}, 32'd0);

        // Abort and start together in IDLE: abort wins.
        start_v[1] = 1'b1;
        abort_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        abort_v[1] = 1'b0;
        check_value("ab_st_idle", {31'd0, busy_v[1]}, 32'd0);

        // First add answers infinity: R=inf, Q=24 at bit 3, so bit 3 is a copy -> 24.
        inf_at[0] = add_cnt_v[0] + 1;
        a0 = add_cnt_v[0];
        d0 = dbl_cnt_v[0];
        run_op(0, 8'h0B, cyc);
        inf_at[0] = -1;
        check_value("inf_x",    {24'd0, ox_v[0]}, 32'd24);
        check_value("inf_inf",  {31'd0, oinf_v[0]}, 32'd0);
        check_value("inf_adds", add_cnt_v[0] - a0, 32'd1);
        check_value("inf_dbls", dbl_cnt_v[0] - d0, 32'd3);

        // Reset asserted between clock edges while waiting on the doubler.
        key = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (gen_dut[0].dbl_bus.start !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_value("dbl_req_seen", {31'd0, gen_dut[0].dbl_bus.start}, 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_value("arst_busy",   {31'd0, busy_v[0]}, 32'd0);
        check_value("arst_out_x",  {24'd0, ox_v[0]}, 32'd0);
        check_value("arst_out_y",  {24'd0, oy_v[0]}, 32'd0);
        check_value("arst_dbl_px", {24'd0, gen_dut[0].dbl_bus.px}, 32'd0);
        check_value("arst_dbl_st", {31'd0, gen_dut[0].dbl_bus.start}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
